// File: rtl/pc_state_sequencer.sv
// pc_state_sequencer: multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer owning the PC; optional SEQ_STALL_EN adds a stall input
module pc_state_sequencer #(
    parameter int IMEM_DEPTH = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SEQ_STALL_EN
    input  logic             stall,
`endif
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic [31:0]      branch_off,
    output logic [31:0]      PC,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [3:0] {
        FETCH = 4'b0000, DECODE = 4'b0001, EXECUTE = 4'b0010,
        MEMORY = 4'b0011, WRITEBACK = 4'b0100, HALT = 4'b1111
    } state_t;
    typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE, C_BR} cls_t;
    state_t st, st_n;
    cls_t cls, cls_n, dec;
    logic [31:0] pc_n;
    logic [CNT_W-1:0] ret_n;
    logic legal, done, hold;
`ifdef SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif
    assign state = st;
    assign legal = opcode == 7'b0110011 || opcode == 7'b0010011 || opcode == 7'b0000011 ||
                   opcode == 7'b0100011 || opcode == 7'b1100011;
    assign dec = opcode == 7'b0000011 ? C_LOAD :
                 opcode == 7'b0100011 ? C_STORE :
                 opcode == 7'b1100011 ? C_BR : C_ALU;
    always_comb begin
        st_n = st;
        cls_n = cls;
        pc_n = PC;
        ret_n = retired;
        done = 1'b0;
        case (st)
            FETCH:     st_n = DECODE;
            DECODE: begin
                cls_n = dec;
                st_n = legal ? EXECUTE : HALT;
            end
            EXECUTE: begin
                st_n = cls == C_ALU ? WRITEBACK : MEMORY;
                done = cls == C_BR;
            end
            MEMORY: begin
                st_n = cls == C_LOAD ? WRITEBACK : FETCH;
                done = cls != C_LOAD;
            end
            WRITEBACK: done = 1'b1;
            default:   st_n = HALT;
        endcase
        if (done) begin
            pc_n = (cls == C_BR && branch_taken) ? PC + branch_off : PC + 32'd1;
            ret_n = &retired ? retired : retired + 1'b1;
            st_n = pc_n >= 32'(IMEM_DEPTH) ? HALT : FETCH;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= FETCH;
            cls <= C_ALU;
            PC <= '0;
            retired <= '0;
            halted <= 1'b0;
        end else if (!hold) begin
            st <= st_n;
            cls <= cls_n;
            PC <= pc_n;
            retired <= ret_n;
            halted <= st_n == HALT;
        end
    end
endmodule

// File: tb/tb_pc_state_sequencer.sv
// tb_pc_state_sequencer: directed self-checking bench for pc_state_sequencer
module tb_pc_state_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic branch_taken = 1'b0;
    logic [31:0] branch_off = 32'd0;
    logic [31:0] PC;
    logic [3:0] state;
    logic halted;
    logic [15:0] retired;
    int checks = 0;
    int failures = 0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011;

    pc_state_sequencer dut (
        .clk(clk),
        .rst(rst),
`ifdef SEQ_STALL_EN
        .stall(stall),
`endif
        .opcode(opcode),
        .branch_taken(branch_taken),
        .branch_off(branch_off),
        .PC(PC),
        .state(state),
        .halted(halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic branch_to(input logic [31:0] off);
        opcode = OP_BR;
        branch_taken = 1'b1;
        branch_off = off;
        step(3);
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] seq [4];
        seq = '{4'h1, 4'h2, 4'h4, 4'h0};
        opcode = OP_R;
        do_reset();
        checks++;
        if ({state, PC, halted, retired} !== {4'h0, 32'd0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL reset got state=%h PC=%0d halted=%b retired=%0d exp 0/0/0/0", state, PC, halted, retired);
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if (state !== seq[i]) begin
                failures++;
                $display("FAIL rtype_seq[%0d] got=%h exp=%h", i, state, seq[i]);
            end
            if (i < 3) begin
                checks++;
                if (PC !== 32'd0) begin
                    failures++;
                    $display("FAIL rtype_pc_hold[%0d] got=%0d exp=0", i, PC);
                end
            end
        end
        checks++;
        if ({PC, retired} !== {32'd1, 16'd1}) begin
            failures++;
            $display("FAIL rtype_done got PC=%0d retired=%0d exp 1/1", PC, retired);
        end
    endtask

    task automatic test_load_store();
        logic [3:0] seq [9];
        seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            opcode = i < 5 ? OP_LD : OP_ST;
            step(1);
            checks++;
            if (state !== seq[i]) begin
                failures++;
                $display("FAIL ldst_seq[%0d] got=%h exp=%h", i, state, seq[i]);
            end
        end
        checks++;
        if ({PC, retired, halted} !== {32'd2, 16'd2, 1'b0}) begin
            failures++;
            $display("FAIL ldst_done got PC=%0d retired=%0d halted=%b exp 2/2/0", PC, retired, halted);
        end
    endtask

    task automatic test_branch();
        logic [31:0] offs [4];
        logic tk [4];
        logic [31:0] exp_pc [4];
        offs = '{32'd5, -32'sd3, 32'd3, -32'sd3};
        tk = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_pc = '{32'd5, 32'd2, 32'd5, 32'd6};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            opcode = OP_BR;
            branch_taken = tk[i];
            branch_off = offs[i];
            step(3);
            checks++;
            if ({state, PC} !== {4'h0, exp_pc[i]}) begin
                failures++;
                $display("FAIL branch[%0d] got state=%h PC=%0d exp state=0 PC=%0d", i, state, PC, exp_pc[i]);
            end
        end
        checks++;
        if (retired !== 16'd4) begin
            failures++;
            $display("FAIL branch_retired got=%0d exp=4", retired);
        end
        opcode = OP_I;
        step(4);
        checks++;
        if ({state, PC, retired} !== {4'h0, 32'd7, 16'd5}) begin
            failures++;
            $display("FAIL ialu got state=%h PC=%0d retired=%0d exp 0/7/5", state, PC, retired);
        end
    endtask

    task automatic test_illegal(input logic [6:0] op);
        do_reset();
        branch_to(32'd4);
        opcode = op;
        step(1);
        checks++;
        if ({state, halted} !== {4'h1, 1'b0}) begin
            failures++;
            $display("FAIL illegal_decode op=%b got state=%h halted=%b exp 1/0", op, state, halted);
        end
        step(1);
        checks++;
        if ({state, halted, PC, retired} !== {4'hf, 1'b1, 32'd4, 16'd1}) begin
            failures++;
            $display("FAIL illegal_halt op=%b got state=%h halted=%b PC=%0d retired=%0d exp f/1/4/1", op, state, halted, PC, retired);
        end
        opcode = OP_R;
        step(20);
        checks++;
        if ({state, halted, PC, retired} !== {4'hf, 1'b1, 32'd4, 16'd1}) begin
            failures++;
            $display("FAIL halt_absorb got state=%h halted=%b PC=%0d retired=%0d exp f/1/4/1", state, halted, PC, retired);
        end
        rst = 1'b1;
        step(1);
        checks++;
        if ({state, halted, PC, retired} !== {4'h0, 1'b0, 32'd0, 16'd0}) begin
            failures++;
            $display("FAIL halt_reset got state=%h halted=%b PC=%0d retired=%0d exp 0/0/0/0", state, halted, PC, retired);
        end
        rst = 1'b0;
    endtask

    task automatic test_end_of_mem();
        do_reset();
        branch_to(32'd14);
        checks++;
        if ({state, PC, halted} !== {4'h0, 32'd14, 1'b0}) begin
            failures++;
            $display("FAIL eom_pc14 got state=%h PC=%0d halted=%b exp 0/14/0", state, PC, halted);
        end
        opcode = OP_R;
        step(4);
        checks++;
        if ({state, PC, halted, retired} !== {4'hf, 32'd15, 1'b1, 16'd2}) begin
            failures++;
            $display("FAIL eom_rtype got state=%h PC=%0d halted=%b retired=%0d exp f/15/1/2", state, PC, halted, retired);
        end
        step(3);
        checks++;
        if ({state, PC, retired} !== {4'hf, 32'd15, 16'd2}) begin
            failures++;
            $display("FAIL eom_frozen got state=%h PC=%0d retired=%0d exp f/15/2", state, PC, retired);
        end
        do_reset();
        branch_to(32'd3);
        branch_to(-32'sd20);
        checks++;
        if ({state, PC, halted, retired} !== {4'hf, 32'hFFFF_FFEF, 1'b1, 16'd2}) begin
            failures++;
            $display("FAIL eom_neg got state=%h PC=%h halted=%b retired=%0d exp f/ffffffef/1/2", state, PC, halted, retired);
        end
    endtask

`ifdef SEQ_STALL_EN
    task automatic test_stall();
        do_reset();
        opcode = OP_R;
        step(2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if ({state, PC} !== {4'h2, 32'd0}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got state=%h PC=%0d exp 2/0", i, state, PC);
            end
        end
        stall = 1'b0;
        step(1);
        checks++;
        if (state !== 4'h4) begin
            failures++;
            $display("FAIL stall_release got=%h exp=4", state);
        end
        step(1);
        checks++;
        if ({state, PC, retired} !== {4'h0, 32'd1, 16'd1}) begin
            failures++;
            $display("FAIL stall_done got state=%h PC=%0d retired=%0d exp 0/1/1", state, PC, retired);
        end
        step(1);
        stall = 1'b1;
        rst = 1'b1;
        step(1);
        checks++;
        if ({state, PC, retired, halted} !== {4'h0, 32'd0, 16'd0, 1'b0}) begin
            failures++;
            $display("FAIL stall_reset got state=%h PC=%0d retired=%0d halted=%b exp 0/0/0/0", state, PC, retired, halted);
        end
        rst = 1'b0;
        stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_store();
        test_branch();
        test_illegal(7'b0000000);
        test_illegal(7'b1111111);
        test_end_of_mem();
`ifdef SEQ_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_state_sequencer.md
Name: pc_state_sequencer

Overview:
- Multicycle sequencer directly upstream of the instruction-memory read stage.
- Owns the program counter and the 4-bit datapath state. The memory stage samples the instruction at the rising edge where state == FETCH.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK according to its opcode, then advances or branches the PC.
- PC is a word index into instruction memory, not a byte address.

Parameters:
- IMEM_DEPTH, 15, number of instruction words; the highest valid PC is IMEM_DEPTH-1.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  7  instruction[6:0] from the memory stage; valid from DECODE onward.
- branch_taken  input  1  branch condition from the ALU; valid in EXECUTE.
- branch_off  input  32  signed word offset for a branch, computed by the decoder; valid in EXECUTE.
- PC  output  32  current instruction word index.
- state  output  4  current sequencer state.
- halted  output  1  high once HALT is entered.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values: PC=0, state=FETCH, halted=0, retired=0. rst has priority over every other condition, in any state, including mid-instruction and HALT.
- State encodings: FETCH=4'b0000, DECODE=0001, EXECUTE=0010, MEMORY=0011, WRITEBACK=0100, HALT=1111.
- FETCH -> DECODE unconditionally. PC is held stable during FETCH.
- In DECODE, opcode is latched into an internal class register. Later states use only the latched class.
- Classes and paths:
  - R-type (0110011) and I-ALU (0010011): D -> E -> WB -> F.
  - Load (0000011): D -> E -> M -> WB -> F.
  - Store (0100011): D -> E -> M -> F.
  - Branch (1100011): D -> E -> F.
  - Any other opcode, including 0000000: D -> HALT. Nothing retires and PC is unchanged.
- PC update happens only on the edge that leaves an instruction's final state into FETCH:
  - Non-branch: PC <= PC+1.
  - Branch: PC <= taken ? PC + branch_off : PC+1.
  - Addition is 32-bit two's-complement and wraps modulo 2^32.
- On that same edge, retired increments by 1. retired saturates at all-ones and does not wrap.
- Bounds check: if the next PC would be >= IMEM_DEPTH, treated as unsigned (this catches negative results):
  - go to HALT instead of FETCH;
  - still update PC to the computed value;
  - still increment retired.
- HALT:
  - absorbing; only rst exits it;
  - halted=1 from the first cycle in HALT onward;
  - PC and retired are frozen.
- Latency: cycles per instruction are R/I = 4, load = 5, store = 4, branch = 3.

Optional Feature:
- Macro: SEQ_STALL_EN.
- With the macro defined:
  - an extra input port `stall` (1 bit) is added;
  - while stall=1 and rst=0, state, PC, retired, halted and the class register hold their values;
  - rst overrides stall;
  - a stall asserted in FETCH keeps state==FETCH, so the memory stage re-reads the same PC, which is harmless.
- Without the macro: the port does not exist and the sequencer never pauses.

Test Plan:
- Reset and fetch: assert rst for 2 cycles, then release with opcode=0110011 from DECODE onward -> state sequence 0000, 0001, 0010, 0100, 0000; PC goes 0 -> 1 on the 4th edge; retired=1.
- Load then store: opcode=0000011 for the first instruction, then 0100011 -> load visits MEMORY then WRITEBACK (5 cycles); store goes MEMORY -> FETCH (4 cycles); PC=2, retired=2 after 9 edges.
- Branch: PC=5, opcode=1100011, branch_taken=1, branch_off=-3 -> after 3 cycles PC=2. Repeat with taken=0 -> PC=6.
- Illegal opcode: opcode=0000000 in DECODE -> HALT next edge; halted=1, PC unchanged, retired unchanged, state stays 1111 for 20 cycles; rst returns PC=0, state=0000.
- End of memory: PC=14, IMEM_DEPTH=15, R-type -> PC=15, state=1111, halted=1, retired incremented. A branch with branch_off=-20 from PC=3 also halts.
- Stall (SEQ_STALL_EN): stall=1 for 3 cycles while in EXECUTE -> state stays 0010 and PC is unchanged; after release, completion is exactly 3 cycles later than unstalled. rst during a stall -> reset values on the next edge.
